// File: rtl/tp_mode_sched_pkg.sv
// tp_pkg: shared types and constants for the test-pattern mode scheduler.
//   preset_t      - one timing preset (8 x 12-bit timing fields + sync polarities)
//   PRESET_TABLE  - the supported timing presets, indexed by preset number
//   state_t       - scheduler FSM states
package tp_pkg;

    localparam int unsigned NUM_PRESETS = 4;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_bporch;
        logic [11:0] h_res;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_bporch;
        logic [11:0] v_res;
        logic        hs_pol;  // 1 = active-high
        logic        vs_pol;  // 1 = active-high
    } preset_t;

    localparam preset_t PRESET_TABLE [NUM_PRESETS] = '{
        // 640x480
        '{12'd800,  12'd96,  12'd48,  12'd640,  12'd525, 12'd2, 12'd33, 12'd480, 1'b0, 1'b0},
        // 800x600
        '{12'd1056, 12'd128, 12'd88,  12'd800,  12'd628, 12'd4, 12'd23, 12'd600, 1'b1, 1'b1},
        // 1280x720
        '{12'd1650, 12'd40,  12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720, 1'b1, 1'b1},
        // 1024x768
        '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768, 1'b0, 1'b0}
    };

    typedef enum logic [1:0] {
        StIdle,
        StWaitFrame,
        StGenRst
    } state_t;

endpackage

// File: rtl/tp_mode_sched_if.sv
// tp_mode_sched_if: host request channel (valid/ready handshake).
//   I_req_valid  - host request valid
//   O_req_ready  - scheduler can accept a request
//   I_req_preset - requested timing preset index
//   I_req_mode   - requested pattern mode
// Signal names are written from the scheduler's point of view.
interface tp_mode_sched_if;

    logic       I_req_valid;
    logic       O_req_ready;
    logic [1:0] I_req_preset;
    logic [2:0] I_req_mode;

    modport master (
        output I_req_valid,
        output I_req_preset,
        output I_req_mode,
        input  O_req_ready
    );

    modport slave (
        input  I_req_valid,
        input  I_req_preset,
        input  I_req_mode,
        output O_req_ready
    );

endinterface

// File: rtl/tp_mode_sched_frame_edge.sv
// tp_frame_edge: polarity-aware vertical-sync leading-edge detector.
//   I_clk, I_rst_n - pixel clock, async active-low reset
//   I_vs           - raw VS from the generator
//   I_vs_pol       - 1 = VS active-high
//   I_suppress     - hold the history register at "active" so no edge can fire
//   O_frame_start  - one-cycle pulse on the first active VS sample
module tp_frame_edge (
    input  logic I_clk,
    input  logic I_rst_n,
    input  logic I_vs,
    input  logic I_vs_pol,
    input  logic I_suppress,
    output logic O_frame_start
);

    logic w_vs_act;
    logic r_vs_d;

    assign w_vs_act = I_vs_pol ? I_vs : ~I_vs;

    // Forcing the history to 1 while suppressed also covers the first cycle after
    // suppression ends, so a VS that is already active then is not seen as an edge.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_vs_d <= 1'b1;
        end else if (I_suppress) begin
            r_vs_d <= 1'b1;
        end else begin
            r_vs_d <= w_vs_act;
        end
    end

    assign O_frame_start = w_vs_act & ~r_vs_d & ~I_suppress;

endmodule

// File: rtl/tp_mode_sched.sv
// tp_mode_sched: frame-synchronous timing preset / pattern mode controller.
//   I_pxl_clk, I_rst_n - pixel clock, async active-low reset
//   host               - request channel (slave side): preset + mode change requests
//   I_auto_en          - step the pattern mode every FRAMES_PER_STEP frames
//   I_vs               - generator VS, polarity given by O_vs_pol
//   O_h_* / O_v_*      - applied timing; O_hs_pol / O_vs_pol applied sync polarity
//   O_mode             - applied pattern mode
//   O_gen_rst_n        - generator reset, low for GEN_RST_CYCLES after a timing change
//   O_err              - one-cycle pulse when a request is rejected
//   O_frame_cnt        - frames seen since reset (wraps)
module tp_mode_sched
    import tp_pkg::*;
#(
    parameter int unsigned NUM_PATTERNS    = 4,
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned GEN_RST_CYCLES  = 4
) (
    input  logic             I_pxl_clk,
    input  logic             I_rst_n,
    tp_mode_sched_if.slave   host,
    input  logic             I_auto_en,
    input  logic             I_vs,
    output logic [11:0]      O_h_total,
    output logic [11:0]      O_h_sync,
    output logic [11:0]      O_h_bporch,
    output logic [11:0]      O_h_res,
    output logic [11:0]      O_v_total,
    output logic [11:0]      O_v_sync,
    output logic [11:0]      O_v_bporch,
    output logic [11:0]      O_v_res,
    output logic             O_hs_pol,
    output logic             O_vs_pol,
    output logic [2:0]       O_mode,
    output logic             O_gen_rst_n,
    output logic             O_err,
    output logic [15:0]      O_frame_cnt
);

    localparam int unsigned AUTO_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int unsigned RST_W  = $clog2(GEN_RST_CYCLES);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(FRAMES_PER_STEP - 1);
    localparam logic [RST_W-1:0]  RST_LOAD  = RST_W'(GEN_RST_CYCLES - 1);
    localparam logic [2:0]        MODE_LAST = 3'(NUM_PATTERNS - 1);

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_preset, w_preset_nxt;
    logic [2:0]        r_mode, w_mode_nxt;
    logic [1:0]        r_pend_preset, w_pend_preset_nxt;
    logic [2:0]        r_pend_mode, w_pend_mode_nxt;
    logic              r_gen_rst_n, w_gen_rst_n_nxt;
    logic              r_err, w_err_nxt;
    logic [15:0]       r_frame_cnt, w_frame_cnt_nxt;
    logic [AUTO_W-1:0] r_auto_cnt, w_auto_cnt_nxt;
    logic [RST_W-1:0]  r_rst_cnt, w_rst_cnt_nxt;
    logic              w_frame_start;
    logic              w_host_apply;
    preset_t           w_timing;

    assign w_timing = PRESET_TABLE[r_preset];

    tp_frame_edge u_frame_edge (
        .I_clk         (I_pxl_clk),
        .I_rst_n       (I_rst_n),
        .I_vs          (I_vs),
        .I_vs_pol      (w_timing.vs_pol),
        .I_suppress    (~r_gen_rst_n),
        .O_frame_start (w_frame_start)
    );

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_state       <= StGenRst;
            r_preset      <= '0;
            r_mode        <= '0;
            r_pend_preset <= '0;
            r_pend_mode   <= '0;
            r_gen_rst_n   <= 1'b0;
            r_err         <= 1'b0;
            r_frame_cnt   <= '0;
            r_auto_cnt    <= '0;
            r_rst_cnt     <= RST_LOAD;
        end else begin
            r_state       <= w_state_nxt;
            r_preset      <= w_preset_nxt;
            r_mode        <= w_mode_nxt;
            r_pend_preset <= w_pend_preset_nxt;
            r_pend_mode   <= w_pend_mode_nxt;
            r_gen_rst_n   <= w_gen_rst_n_nxt;
            r_err         <= w_err_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_auto_cnt    <= w_auto_cnt_nxt;
            r_rst_cnt     <= w_rst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_preset_nxt      = r_preset;
        w_mode_nxt        = r_mode;
        w_pend_preset_nxt = r_pend_preset;
        w_pend_mode_nxt   = r_pend_mode;
        w_gen_rst_n_nxt   = r_gen_rst_n;
        w_err_nxt         = 1'b0;
        w_rst_cnt_nxt     = r_rst_cnt;
        w_auto_cnt_nxt    = r_auto_cnt;
        w_host_apply      = 1'b0;

        unique case (r_state)
            StIdle: begin
                // A 2-bit preset index always lands inside the 4-entry table, so only
                // the mode can be out of range.
                if (host.I_req_valid) begin
                    if (32'(host.I_req_mode) >= NUM_PATTERNS) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_pend_preset_nxt = host.I_req_preset;
                        w_pend_mode_nxt   = host.I_req_mode;
                        w_state_nxt       = StWaitFrame;
                    end
                end
            end
            StWaitFrame: begin
                if (w_frame_start) begin
                    w_host_apply = 1'b1;
                    w_mode_nxt   = r_pend_mode;
                    if (r_pend_preset != r_preset) begin
                        w_preset_nxt    = r_pend_preset;
                        w_gen_rst_n_nxt = 1'b0;
                        w_rst_cnt_nxt   = RST_LOAD;
                        w_state_nxt     = StGenRst;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StGenRst: begin
                // Count out the low period, spend one cycle released, then accept requests.
                if (r_rst_cnt != '0) begin
                    w_rst_cnt_nxt = r_rst_cnt - 1'b1;
                end else if (!r_gen_rst_n) begin
                    w_gen_rst_n_nxt = 1'b1;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Auto step; an applied host request takes the frame and restarts the count.
        if (!I_auto_en || w_host_apply) begin
            w_auto_cnt_nxt = '0;
        end else if (w_frame_start) begin
            if (r_auto_cnt == AUTO_LAST) begin
                w_auto_cnt_nxt = '0;
                if (r_state == StIdle) begin
                    w_mode_nxt = (r_mode == MODE_LAST) ? 3'd0 : r_mode + 3'd1;
                end
            end else begin
                w_auto_cnt_nxt = r_auto_cnt + 1'b1;
            end
        end

        w_frame_cnt_nxt = r_frame_cnt + {15'd0, w_frame_start};
    end

    assign host.O_req_ready = (r_state == StIdle);

    assign O_h_total   = w_timing.h_total;
    assign O_h_sync    = w_timing.h_sync;
    assign O_h_bporch  = w_timing.h_bporch;
    assign O_h_res     = w_timing.h_res;
    assign O_v_total   = w_timing.v_total;
    assign O_v_sync    = w_timing.v_sync;
    assign O_v_bporch  = w_timing.v_bporch;
    assign O_v_res     = w_timing.v_res;
    assign O_hs_pol    = w_timing.hs_pol;
    assign O_vs_pol    = w_timing.vs_pol;
    assign O_mode      = r_mode;
    assign O_gen_rst_n = r_gen_rst_n;
    assign O_err       = r_err;
    assign O_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_tp_mode_sched.sv
// tb_tp_mode_sched: directed table + hand sequences, then randomized traffic checked
// every cycle against an event-level reference model of the scheduler.
module tb_tp_mode_sched;

    localparam int NP  = 4;
    localparam int FPS = 3;
    localparam int GR  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        auto_en;
    logic        vs;
    logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic        hs_pol, vs_pol;
    logic [2:0]  mode;
    logic        gen_rst_n;
    logic        err;
    logic [15:0] frame_cnt;

    tp_mode_sched_if host_if ();

    tp_mode_sched #(
        .NUM_PATTERNS    (NP),
        .FRAMES_PER_STEP (FPS),
        .GEN_RST_CYCLES  (GR)
    ) dut (
        .I_pxl_clk   (clk),
        .I_rst_n     (rst_n),
        .host        (host_if),
        .I_auto_en   (auto_en),
        .I_vs        (vs),
        .O_h_total   (h_total),
        .O_h_sync    (h_sync),
        .O_h_bporch  (h_bporch),
        .O_h_res     (h_res),
        .O_v_total   (v_total),
        .O_v_sync    (v_sync),
        .O_v_bporch  (v_bporch),
        .O_v_res     (v_res),
        .O_hs_pol    (hs_pol),
        .O_vs_pol    (vs_pol),
        .O_mode      (mode),
        .O_gen_rst_n (gen_rst_n),
        .O_err       (err),
        .O_frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Expected presets: h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res
    int unsigned exp_tim [4][8] = '{
        '{800,  96,  48,  640,  525, 2, 33, 480},
        '{1056, 128, 88,  800,  628, 4, 23, 600},
        '{1650, 40,  220, 1280, 750, 5, 20, 720},
        '{1344, 136, 160, 1024, 806, 6, 29, 768}
    };
    bit exp_pol [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    int n_total = 0;
    int n_pass  = 0;
    bit act_pol = 1'b0;
    int exp_frames = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [97:0] tim_got();
        return {h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res,
                hs_pol, vs_pol};
    endfunction

    function automatic logic [97:0] tim_exp(input int p);
        logic [97:0] v = '0;
        for (int k = 0; k < 8; k++) v = (v << 12) | 98'(exp_tim[p][k]);
        v = (v << 2) | {96'd0, exp_pol[p], exp_pol[p]};
        return v;
    endfunction

    task automatic set_vs(input bit active);
        vs = act_pol ? active : ~active;
    endtask

    // Counts cycles with the generator reset low, then checks ready comes back one
    // cycle after release.
    task automatic wait_release(input string name, input int exp_low);
        int low = 0;
        for (int i = 0; i < 20 && gen_rst_n !== 1'b1; i++) begin
            low++;
            @(negedge clk);
        end
        chk({name, "_rst_len"}, low, exp_low);
        if (low != 0) begin
            chk({name, "_ready_in_release"}, host_if.O_req_ready, 0);
            @(negedge clk);
        end
        chk({name, "_ready"}, host_if.O_req_ready, 1);
    endtask

    task automatic send_req(input string name, input int p, input int m, input bit exp_err);
        chk({name, "_ready_pre"}, host_if.O_req_ready, 1);
        host_if.I_req_valid  = 1'b1;
        host_if.I_req_preset = 2'(p);
        host_if.I_req_mode   = 3'(m);
        @(negedge clk);
        // Changes after the handshake must be ignored.
        host_if.I_req_valid  = 1'b0;
        host_if.I_req_preset = 2'(p + 1);
        host_if.I_req_mode   = 3'(m ^ 1);
        chk({name, "_err"}, err, exp_err);
        chk({name, "_ready_post"}, host_if.O_req_ready, exp_err);
        @(negedge clk);
        chk({name, "_err_single"}, err, 0);
    endtask

    // One VS pulse, held active through any generator reset to catch false edges.
    task automatic do_frame(input string name, input int e_mode, input int e_p, input int e_low);
        set_vs(1'b1);
        @(negedge clk);
        exp_frames++;
        chk({name, "_mode"}, mode, e_mode);
        chk({name, "_timing"}, tim_got(), tim_exp(e_p));
        chk({name, "_frames"}, frame_cnt, exp_frames);
        act_pol = exp_pol[e_p];
        set_vs(1'b1);
        wait_release(name, e_low);
        repeat (2) @(negedge clk);
        chk({name, "_no_false_edge"}, frame_cnt, exp_frames);
        set_vs(1'b0);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int p;
        int m;
        bit err;
        int e_mode;
        int e_p;
        int e_low;
    } vec_t;

    // ---------------- reference model ----------------
    int          m_preset, m_mode, m_autocnt, m_rst_left, m_pp, m_pm;
    bit          m_release, m_pending, m_err, m_prev_vs;
    logic [15:0] m_frames;

    task automatic model_reset();
        m_preset = 0; m_mode = 0; m_autocnt = 0; m_rst_left = GR;
        m_release = 0; m_pending = 0; m_err = 0; m_prev_vs = 1; m_frames = '0;
        m_pp = 0; m_pm = 0;
    endtask

    function automatic bit m_ready();
        return (m_rst_left == 0) && !m_release && !m_pending;
    endfunction

    // Advance the model across one rising edge given the inputs seen at that edge.
    task automatic model_step(input bit v, input int rp, input int rm, input bit ae, input bit s);
        bit gen_ok  = (m_rst_left == 0);
        bit idle    = m_ready();
        bit vs_act  = exp_pol[m_preset] ? s : !s;
        bit fs      = gen_ok && vs_act && !m_prev_vs;
        bit applied = 0;
        m_prev_vs = gen_ok ? vs_act : 1'b1;
        m_err     = v && idle && (rm >= NP);
        if (fs) m_frames = m_frames + 16'd1;
        if (m_rst_left > 0) begin
            m_rst_left--;
            if (m_rst_left == 0) m_release = 1;
        end else begin
            m_release = 0;
        end
        if (m_pending && fs) begin
            applied   = 1;
            m_pending = 0;
            m_mode    = m_pm;
            if (m_pp != m_preset) begin
                m_preset   = m_pp;
                m_rst_left = GR;
            end
        end else if (v && idle && rm < NP) begin
            m_pending = 1;
            m_pp      = rp;
            m_pm      = rm;
        end
        if (!ae || applied) begin
            m_autocnt = 0;
        end else if (fs) begin
            if (m_autocnt == FPS - 1) begin
                m_autocnt = 0;
                if (idle) m_mode = (m_mode + 1) % NP;
            end else begin
                m_autocnt++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   cur_mode;
        int   vpos, flen;
        bit   rv;
        int   rp, rm;

        vecs[0] = '{0, 2, 1'b0, 2, 0, 0};
        vecs[1] = '{2, 1, 1'b0, 1, 2, 4};
        vecs[2] = '{2, 5, 1'b1, 1, 2, 0};
        vecs[3] = '{1, 3, 1'b0, 3, 1, 4};
        vecs[4] = '{3, 0, 1'b0, 0, 3, 4};
        vecs[5] = '{3, 7, 1'b1, 0, 3, 0};
        vecs[6] = '{0, 3, 1'b0, 3, 0, 4};

        host_if.I_req_valid  = 1'b0;
        host_if.I_req_preset = 2'd0;
        host_if.I_req_mode   = 3'd0;
        auto_en = 1'b0;
        act_pol = 1'b0;
        set_vs(1'b0);
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_timing", tim_got(), tim_exp(0));
        chk("rst_gen_rst_n", gen_rst_n, 0);
        chk("rst_ready", host_if.O_req_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_frames", frame_cnt, 0);
        rst_n = 1'b1;
        wait_release("rst_release", GR);

        // Table of requests applied in sequence
        cur_mode = 0;
        for (int i = 0; i < 7; i++) begin
            send_req($sformatf("vec%0d", i), vecs[i].p, vecs[i].m, vecs[i].err);
            if (vecs[i].err) begin
                chk($sformatf("vec%0d_mode_kept", i), mode, vecs[i].e_mode);
                chk($sformatf("vec%0d_timing_kept", i), tim_got(), tim_exp(vecs[i].e_p));
            end else begin
                repeat (3) @(negedge clk);
                chk($sformatf("vec%0d_held", i), mode, cur_mode);
                chk($sformatf("vec%0d_waiting", i), host_if.O_req_ready, 0);
                do_frame($sformatf("vec%0d", i), vecs[i].e_mode, vecs[i].e_p, vecs[i].e_low);
            end
            cur_mode = vecs[i].e_mode;
        end

        // Auto step: 3 -> 0 -> 1 -> 2 -> 3 -> 0, one step every FPS frames
        auto_en = 1'b1;
        for (int s = 0; s < 5; s++) begin
            for (int f = 0; f < FPS; f++) begin
                if (f == FPS - 1) cur_mode = (cur_mode + 1) % NP;
                do_frame($sformatf("auto%0d_%0d", s, f), cur_mode, 0, 0);
            end
        end
        // Host request lands on the step frame and wins; auto count restarts
        do_frame("pre_host0", 0, 0, 0);
        do_frame("pre_host1", 0, 0, 0);
        send_req("host_wins", 0, 2, 1'b0);
        do_frame("host_wins", 2, 0, 0);
        do_frame("post_host0", 2, 0, 0);
        do_frame("post_host1", 2, 0, 0);
        do_frame("post_host2", 3, 0, 0);
        auto_en = 1'b0;

        // Reset while a request is pending
        send_req("rst_pend", 2, 1, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mode", mode, 0);
        chk("midrst_timing", tim_got(), tim_exp(0));
        chk("midrst_frames", frame_cnt, 0);
        chk("midrst_gen_rst_n", gen_rst_n, 0);
        chk("midrst_ready", host_if.O_req_ready, 0);
        exp_frames = 0;
        act_pol = 1'b0;
        set_vs(1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_release("midrst_release", GR);
        do_frame("midrst_dropped", 0, 0, 0);

        // Randomized traffic against the reference model
        rst_n = 1'b0;
        model_reset();
        auto_en = 1'b1;
        vpos = 0;
        flen = 20;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #1;
            end
            if (cyc == 1502) rst_n = 1'b1;
            chk("rand_mode", mode, m_mode);
            chk("rand_timing", tim_got(), tim_exp(m_preset));
            chk("rand_gen_rst_n", gen_rst_n, m_rst_left == 0);
            chk("rand_ready", host_if.O_req_ready, m_ready());
            chk("rand_err", err, m_err);
            chk("rand_frames", frame_cnt, m_frames);
            rv = ($urandom_range(0, 7) == 0);
            rp = $urandom_range(0, 3);
            rm = $urandom_range(0, 5);
            host_if.I_req_valid  = rv;
            host_if.I_req_preset = 2'(rp);
            host_if.I_req_mode   = 3'(rm);
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            if (vpos == 0) flen = $urandom_range(12, 30);
            vs = exp_pol[m_preset] ? (vpos < 2) : !(vpos < 2);
            vpos = (vpos + 1 >= flen) ? 0 : vpos + 1;
            if (rst_n) model_step(rv, rp, rm, auto_en, vs);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
